// File: rtl/hi5_pkg.sv
// Shared definitions for the HI5 register-load path: instruction format, opcodes,
// request modes and the emitter FSM states.
package hi5_pkg;

  localparam int unsigned HI5_W     = 36;
  localparam int unsigned HI5_OPC_W = 4;

  localparam logic [HI5_OPC_W-1:0] TEST32_OPC = 4'h1;
  localparam logic [HI5_OPC_W-1:0] LOW32_OPC  = 4'h2;
  localparam logic [HI5_OPC_W-1:0] HIGH32_OPC = 4'h3;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    HIGH = 2'd1,
    FULL = 2'd2,
    TEST = 2'd3
  } hi5_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StEmitLo,
    StEmitHi,
    StEmitTst
  } hi5_emit_state_t;

  // First emit state for a freshly accepted request.
  function automatic hi5_emit_state_t hi5_first_state(input hi5_mode_t mode);
    unique case (mode)
      LOW, FULL: return StEmitLo;
      HIGH:      return StEmitHi;
      TEST:      return StEmitTst;
      default:   return StEmitLo;
    endcase
  endfunction

endpackage

// File: rtl/hi5_const_emitter.sv
// Serialises 64-bit constant-load requests into one or two 36-bit HI5 instruction
// words on a valid/ready stream, counting every transferred word.
module hi5_const_emitter
  import hi5_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [63:0]      req_data,
  output logic [HI5_W-1:0] code,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  hi5_emit_state_t state_q, state_d;
  hi5_mode_t       mode_q, mode_d;
  logic [63:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q;

  logic last_word;
  logic xfer;
  logic accept;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    data_d     = data_q;
    code       = '0;
    code_valid = 1'b0;
    last_word  = 1'b0;

    unique case (state_q)
      StIdle: ;
      StEmitLo: begin
        code_valid = 1'b1;
        code       = {LOW32_OPC, data_q[31:0]};
        last_word  = (mode_q != FULL);
      end
      StEmitHi: begin
        code_valid = 1'b1;
        code       = {HIGH32_OPC, data_q[63:32]};
        last_word  = 1'b1;
      end
      StEmitTst: begin
        code_valid = 1'b1;
        code       = {TEST32_OPC, data_q[31:0]};
        last_word  = 1'b1;
      end
      default: ;
    endcase

    xfer      = code_valid && code_ready;
    // Never depends on req_valid, so the source cannot form a combinational loop.
    req_ready = (state_q == StIdle) || (last_word && xfer);
    accept    = req_valid && req_ready;

    if (xfer) begin
      state_d = last_word ? StIdle : StEmitHi;
    end
    // A request accepted alongside the last word overrides the return to idle.
    if (accept) begin
      mode_d  = hi5_mode_t'(req_mode);
      data_d  = req_data;
      state_d = hi5_first_state(hi5_mode_t'(req_mode));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= LOW;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      if (xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign busy        = (state_q != StIdle);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_hi5_const_emitter.sv
// Directed bench for hi5_const_emitter; a second instance with a 4-bit counter
// shares the stimulus to exercise counter wrap.
module tb_hi5_const_emitter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_mode;
  logic [63:0] req_data;
  logic        code_ready;

  logic        req_ready, code_valid, busy;
  logic [35:0] code;
  logic [15:0] instr_count;

  logic        req_ready_w, code_valid_w, busy_w;
  logic [35:0] code_w;
  logic [3:0]  instr_count_w;

  int vectors = 0;
  int errors  = 0;
  int exp_cnt = 0;

  always #5 clock = ~clock;

  hi5_const_emitter dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mode    (req_mode),
    .req_data    (req_data),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .busy        (busy),
    .instr_count (instr_count)
  );

  hi5_const_emitter #(.CNT_W(4)) dut_w (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready_w),
    .req_mode    (req_mode),
    .req_data    (req_data),
    .code        (code_w),
    .code_valid  (code_valid_w),
    .code_ready  (code_ready),
    .busy        (busy_w),
    .instr_count (instr_count_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " cnt16"}, 64'(instr_count), 64'(exp_cnt & 16'hffff));
    check({tag, " cnt4"}, 64'(instr_count_w), 64'(exp_cnt & 4'hf));
  endtask

  logic [63:0] reg0;
  logic [63:0] cur_data;
  logic        acc, xf, done;
  logic [35:0] cw;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_mode   = 2'd0;
    req_data   = '0;
    code_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check("rst code_valid", 64'(code_valid), 64'd0);
    check("rst code", 64'(code), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd1);
    check_counts("rst");

    // LOW32 single word
    req_valid = 1'b1; req_mode = 2'd0; req_data = 64'h1111_2222_3333_4444; code_ready = 1'b1;
    #1;
    check("low req_ready idle", 64'(req_ready), 64'd1);
    cyc();
    req_valid = 1'b0;
    #1;
    check("low code_valid", 64'(code_valid), 64'd1);
    check("low code", 64'(code), 64'h2_3333_4444);
    check("low busy", 64'(busy), 64'd1);
    check("low req_ready emit", 64'(req_ready), 64'd1);
    check_counts("low before");
    cyc();
    exp_cnt++;
    check("low done valid", 64'(code_valid), 64'd0);
    check_counts("low after");

    // FULL with a 3-cycle stall on the LOW32 word
    code_ready = 1'b0;
    req_valid = 1'b1; req_mode = 2'd2; req_data = 64'hDEAD_BEEF_0123_4567;
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) code_ready = 1'b1;
      #1;
      check("full lo code", 64'(code), 64'h2_0123_4567);
      check("full lo valid", 64'(code_valid), 64'd1);
      check("full lo req_ready", 64'(req_ready), 64'd0);
      cyc();
    end
    #1;
    check("full hi code", 64'(code), 64'h3_DEAD_BEEF);
    check("full hi req_ready", 64'(req_ready), 64'd1);
    cyc();
    exp_cnt += 2;
    check("full done valid", 64'(code_valid), 64'd0);
    check_counts("full");

    // TEST32 / HIGH32 / TEST32 back-to-back
    code_ready = 1'b1;
    req_valid = 1'b1; req_mode = 2'd3; req_data = 64'h5555_5555_0000_000A;
    cyc();
    req_mode = 2'd1; req_data = 64'h0000_000B_6666_6666;
    #1;
    check("b2b tst code", 64'(code), 64'h1_0000_000A);
    check("b2b tst req_ready", 64'(req_ready), 64'd1);
    cyc();
    req_mode = 2'd3; req_data = 64'h7777_7777_0000_000C;
    #1;
    check("b2b hi code", 64'(code), 64'h3_0000_000B);
    cyc();
    req_valid = 1'b0;
    #1;
    check("b2b tst2 code", 64'(code), 64'h1_0000_000C);
    check("b2b tst2 valid", 64'(code_valid), 64'd1);
    cyc();
    exp_cnt += 3;
    check("b2b done valid", 64'(code_valid), 64'd0);
    check_counts("b2b");

    // Reset while the LOW32 word of a FULL request is stalled
    code_ready = 1'b0;
    req_valid = 1'b1; req_mode = 2'd2; req_data = 64'h7777_8888_9999_AAAA;
    cyc();
    req_valid = 1'b0;
    #1;
    check("rstmid lo code", 64'(code), 64'h2_9999_AAAA);
    reset = 1'b1; code_ready = 1'b1; req_valid = 1'b1; req_mode = 2'd3;
    cyc();
    reset = 1'b0; req_valid = 1'b0;
    exp_cnt = 0;
    #1;
    check("rstmid valid", 64'(code_valid), 64'd0);
    check("rstmid req_ready", 64'(req_ready), 64'd1);
    check("rstmid busy", 64'(busy), 64'd0);
    check_counts("rstmid");
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rstmid no hi", 64'(code_valid), 64'd0);
    end

    // 17 LOW32 transfers: narrow counter wraps 15 -> 0 -> 1
    for (int i = 1; i <= 17; i++) begin
      req_valid = 1'b1; req_mode = 2'd0; req_data = 64'(i);
      cyc();
      req_valid = 1'b0;
      check("wrap code", 64'(code), {28'h0, 4'h2, 32'(i)});
      cyc();
      exp_cnt++;
      check_counts("wrap");
    end

    // Loopback into a behavioural decoder, random FULL requests and random stalls
    reg0 = '0;
    for (int r = 0; r < 8; r++) begin
      cur_data  = {$urandom(), $urandom()};
      req_valid = 1'b1; req_mode = 2'd2; req_data = cur_data;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        code_ready = 1'($urandom_range(0, 1));
        #1;
        acc = req_valid && req_ready;
        xf  = code_valid && code_ready;
        cw  = code;
        cyc();
        if (acc) req_valid = 1'b0;
        if (xf) begin
          exp_cnt++;
          if (cw[35:32] == 4'h2) reg0[31:0] = cw[31:0];
          if (cw[35:32] == 4'h3) begin
            reg0[63:32] = cw[31:0];
            check("loop reg0", reg0, cur_data);
            done = 1'b1;
          end
        end
      end
      if (!done) check("loop timeout", 64'd0, 64'd1);
    end
    req_valid = 1'b0;
    code_ready = 1'b1;
    cyc();
    check_counts("loop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
